// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

    // Bytes per instruction word: opcode, reg, addr_lo, addr_hi.
    localparam int INST_BYTES = 4;

    // Address width carried inside a queued instruction.
    localparam int IFQ_PC_W = 8;

    // Opcode encodings understood by the execute stage.
    localparam logic [7:0] OP_MOV_RC = 8'd1;
    localparam logic [7:0] OP_MOV_RM = 8'd2;
    localparam logic [7:0] OP_MOV_MR = 8'd3;
    localparam logic [7:0] OP_ADD_RR = 8'd4;

    // One assembled instruction as held in the queue.
    typedef struct packed {
        logic [7:0]          opcode;
        logic [7:0]          reg_idx;
        logic [15:0]         operand;
        logic [IFQ_PC_W-1:0] pc;
    } inst_t;

    // Fetch sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    // Little-endian 16-bit operand from its two bytes.
    function automatic logic [15:0] le16(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Synchronous FIFO of assembled instructions with flush and occupancy count.
// The head is kept in its own register so that the presented fields stay put
// when the queue runs empty or is flushed.
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  inst_t            push_data,
    input  logic             pop,
    output inst_t            head,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

    inst_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_next_s;
    logic [CNT_W-1:0] count_q, count_d;
    inst_t            head_q, head_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop, advance pointers and count, and select the next head.
    always_comb begin
        rd_next_s = rd_ptr_q + PTR_ONE;
        do_pop_s  = pop && !flush && (count_q != ZERO_CNT);
        do_push_s = push && !flush && ((count_q != FULL_CNT) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        head_d    = head_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = ZERO_CNT;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_next_s;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
            if (do_pop_s) begin
                if (count_q == ONE_CNT) begin
                    if (do_push_s) begin
                        head_d = push_data;
                    end else begin
                        head_d = head_q;
                    end
                end else begin
                    head_d = mem_q[rd_next_s];
                end
            end else if ((count_q == ZERO_CNT) && do_push_s) begin
                head_d = push_data;
            end else begin
                head_d = head_q;
            end
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= ZERO_CNT;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = head_q;
    assign count = count_q;

    // The reservation scheme upstream must never push into a full queue.
    overflow_a : assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && !pop && (count_q == FULL_CNT)));

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: reads the byte-wide program RAM, assembles 4-byte
// instructions and queues them for the execute stage. A redirect flushes all
// buffered and in-flight state and restarts fetch at the new address.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int  PC_W  = IFQ_PC_W,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             mem_rd,
    output logic [PC_W-1:0]  mem_addr,
    input  logic [7:0]       mem_rdata,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [7:0]       inst_opcode,
    output logic [7:0]       inst_reg,
    output logic [15:0]      inst_operand,
    output logic [PC_W-1:0]  inst_pc,
    output logic [CNT_W-1:0] q_count
);

    localparam logic [CNT_W:0]  DEPTH_RES = (CNT_W + 1)'(DEPTH);
    localparam logic [PC_W-1:0] PC_STEP   = PC_W'(INST_BYTES);
    localparam logic [1:0]      LAST_BYTE = 2'd3;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             tag_vld_q, tag_vld_d;
    logic [1:0]       tag_idx_q, tag_idx_d;
    logic             asm_busy_q, asm_busy_d;
    logic [7:0]       asm_b0_q, asm_b0_d;
    logic [7:0]       asm_b1_q, asm_b1_d;
    logic [7:0]       asm_b2_q, asm_b2_d;
    logic [PC_W-1:0]  asm_pc_q, asm_pc_d;

    logic [CNT_W-1:0] count_s;
    logic [CNT_W:0]   reserved_s;
    logic             room_s;
    logic             start_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    inst_t            push_word_s;
    inst_t            head_s;

    // Queue slots already spoken for: held entries plus the word in assembly.
    always_comb begin
        reserved_s = {1'b0, count_s} + {{CNT_W{1'b0}}, asm_busy_q};
        room_s     = (reserved_s < DEPTH_RES);
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state: IDLE issues byte 0 and hands bytes 1..3 to FETCH.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer outputs: byte-0 start is gated by run and a free slot; once
    // started, the remaining bytes are always issued.
    always_comb begin
        start_s = (state_q == ST_IDLE) && run && room_s && !reset;
        case (state_q)
            ST_IDLE:  issue_s = start_s;
            ST_FETCH: issue_s = 1'b1;
            default:  issue_s = 1'b0;
        endcase
        mem_rd   = issue_s;
        mem_addr = pc_q + PC_W'(byte_idx_q);
    end

    // Word push on the returning last byte, and consumer pop; both are
    // dropped in a redirect cycle.
    always_comb begin
        push_s              = tag_vld_q && (tag_idx_q == LAST_BYTE) && !redirect_valid;
        pop_s               = inst_valid && inst_ready && !redirect_valid;
        push_word_s.opcode  = asm_b0_q;
        push_word_s.reg_idx = asm_b1_q;
        push_word_s.operand = le16(asm_b2_q, mem_rdata);
        push_word_s.pc      = IFQ_PC_W'(asm_pc_q);
    end

    // Fetch address, in-flight tag and assembler next-state logic.
    always_comb begin
        pc_d       = pc_q;
        byte_idx_d = byte_idx_q;
        tag_vld_d  = tag_vld_q;
        tag_idx_d  = tag_idx_q;
        asm_busy_d = asm_busy_q;
        asm_b0_d   = asm_b0_q;
        asm_b1_d   = asm_b1_q;
        asm_b2_d   = asm_b2_q;
        asm_pc_d   = asm_pc_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            byte_idx_d = 2'd0;
            tag_vld_d  = 1'b0;
            tag_idx_d  = 2'd0;
            asm_busy_d = 1'b0;
            asm_b0_d   = 8'h00;
            asm_b1_d   = 8'h00;
            asm_b2_d   = 8'h00;
            asm_pc_d   = {PC_W{1'b0}};
        end else begin
            if (issue_s) begin
                if (byte_idx_q == LAST_BYTE) begin
                    byte_idx_d = 2'd0;
                    pc_d       = pc_q + PC_STEP;
                end else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    pc_d       = pc_q;
                end
            end else begin
                byte_idx_d = byte_idx_q;
                pc_d       = pc_q;
            end
            tag_vld_d = issue_s;
            tag_idx_d = byte_idx_q;
            if (start_s) begin
                asm_pc_d   = pc_q;
                asm_busy_d = 1'b1;
            end else if (push_s) begin
                asm_pc_d   = asm_pc_q;
                asm_busy_d = 1'b0;
            end else begin
                asm_pc_d   = asm_pc_q;
                asm_busy_d = asm_busy_q;
            end
            if (tag_vld_q) begin
                case (tag_idx_q)
                    2'd0:    asm_b0_d = mem_rdata;
                    2'd1:    asm_b1_d = mem_rdata;
                    2'd2:    asm_b2_d = mem_rdata;
                    default: asm_b0_d = asm_b0_q;
                endcase
            end else begin
                asm_b0_d = asm_b0_q;
            end
        end
    end

    // Fetch address, in-flight tag and assembler registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= {PC_W{1'b0}};
            byte_idx_q <= 2'd0;
            tag_vld_q  <= 1'b0;
            tag_idx_q  <= 2'd0;
            asm_busy_q <= 1'b0;
            asm_b0_q   <= 8'h00;
            asm_b1_q   <= 8'h00;
            asm_b2_q   <= 8'h00;
            asm_pc_q   <= {PC_W{1'b0}};
        end else begin
            pc_q       <= pc_d;
            byte_idx_q <= byte_idx_d;
            tag_vld_q  <= tag_vld_d;
            tag_idx_q  <= tag_idx_d;
            asm_busy_q <= asm_busy_d;
            asm_b0_q   <= asm_b0_d;
            asm_b1_q   <= asm_b1_d;
            asm_b2_q   <= asm_b2_d;
            asm_pc_q   <= asm_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    assign q_count      = count_s;
    assign inst_valid   = (count_s != {CNT_W{1'b0}});
    assign inst_opcode  = head_s.opcode;
    assign inst_reg     = head_s.reg_idx;
    assign inst_operand = head_s.operand;
    assign inst_pc      = PC_W'(head_s.pc);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a byte-RAM model and a
// scoreboard of expected instruction words.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_opcode;
    logic [7:0]  inst_reg;
    logic [15:0] inst_operand;
    logic [7:0]  inst_pc;
    logic [2:0]  q_count;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  rg;
        logic [15:0] opnd;
        logic [7:0]  pc;
    } exp_t;

    logic [7:0] prog [256];
    exp_t       sbq [$];
    int         checks = 0;
    int         errors = 0;

    instr_fetch_queue #(.PC_W(8), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_opcode    (inst_opcode),
        .inst_reg       (inst_reg),
        .inst_operand   (inst_operand),
        .inst_pc        (inst_pc),
        .q_count        (q_count)
    );

    always #5 clk = ~clk;

    // Program RAM: data returned one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= prog[mem_addr];
        else        mem_rdata <= 8'hEE;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [7:0] op, input logic [7:0] rg,
                               input logic [15:0] opnd, input logic [7:0] pc);
        exp_t e;
        e.op = op; e.rg = rg; e.opnd = opnd; e.pc = pc;
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        chk(name, sbq.size(), 0);
        cyc();
    endtask

    // Monitor: every accepted head is compared against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && !redirect_valid && inst_valid && inst_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word actual pc=%h op=%h expected none", inst_pc, inst_opcode);
            end else begin
                e = sbq.pop_front();
                if ({inst_opcode, inst_reg, inst_operand, inst_pc} !== e) begin
                    errors++;
                    $display("FAIL word actual op=%h reg=%h opnd=%h pc=%h expected op=%h reg=%h opnd=%h pc=%h",
                             inst_opcode, inst_reg, inst_operand, inst_pc, e.op, e.rg, e.opnd, e.pc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int         rd_seen;
        logic [7:0] exp_a [5];
        exp_a[0] = 8'hFC; exp_a[1] = 8'hFD; exp_a[2] = 8'hFE; exp_a[3] = 8'hFF; exp_a[4] = 8'h00;

        for (int a = 0; a < 256; a++) prog[a] = 8'(a + 64);
        prog[8'h00] = 8'h02; prog[8'h01] = 8'h00; prog[8'h02] = 8'h10; prog[8'h03] = 8'h00;
        prog[8'h20] = 8'h03; prog[8'h21] = 8'h07; prog[8'h22] = 8'hCD; prog[8'h23] = 8'hAB;
        prog[8'hFC] = 8'h01; prog[8'hFD] = 8'h05; prog[8'hFE] = 8'h34; prog[8'hFF] = 8'h12;

        reset = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; inst_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_opcode", inst_opcode, 8'h00);
        chk("rst_reg", inst_reg, 8'h00);
        chk("rst_operand", inst_operand, 16'h0000);
        chk("rst_pc", inst_pc, 8'h00);
        chk("rst_q_count", q_count, 3'd0);

        // First word latency: valid 5 cycles after run
        inst_ready = 1'b1;
        cyc();
        run = 1'b1;
        expect_word(8'h02, 8'h00, 16'h0010, 8'h00);
        @(negedge clk);
        chk("first_mem_rd", mem_rd, 1'b1);
        chk("first_mem_addr", mem_addr, 8'h00);
        cyc();
        run = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("latency_4_not_valid", inst_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk("latency_5_valid", inst_valid, 1'b1);
        wait_drain("drain_first");

        // Fill with consumer stalled
        inst_ready = 1'b0;
        run = 1'b1;
        expect_word(8'h44, 8'h45, 16'h4746, 8'h04);
        expect_word(8'h48, 8'h49, 16'h4B4A, 8'h08);
        expect_word(8'h4C, 8'h4D, 16'h4F4E, 8'h0C);
        expect_word(8'h50, 8'h51, 16'h5352, 8'h10);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q_count == 3'd4) break;
        end
        chk("fill_q_count", q_count, 3'd4);
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rd) rd_seen++;
        end
        chk("no_fetch_when_full", rd_seen, 0);
        chk("full_q_count_held", q_count, 3'd4);
        cyc();
        run = 1'b0;
        inst_ready = 1'b1;
        wait_drain("drain_fill");
        @(negedge clk);
        chk("empty_valid", inst_valid, 1'b0);
        chk("empty_q_count", q_count, 3'd0);
        chk("empty_hold_pc", inst_pc, 8'h10);
        chk("empty_hold_opcode", inst_opcode, 8'h50);

        // Redirect during byte 2 with one word queued
        cyc();
        inst_ready = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q_count == 3'd1) break;
        end
        chk("pre_redirect_q", q_count, 3'd1);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 8'h20;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("redirect_byte2_rd", mem_rd, 1'b1);
        chk("redirect_byte2_addr", mem_addr, 8'h1A);
        cyc();
        redirect_valid = 1'b0;
        expect_word(8'h03, 8'h07, 16'hABCD, 8'h20);
        @(negedge clk);
        chk("flush_q_count", q_count, 3'd0);
        chk("flush_valid", inst_valid, 1'b0);
        chk("redirect_target_rd", mem_rd, 1'b1);
        chk("redirect_target_addr", mem_addr, 8'h20);
        cyc();
        run = 1'b0;
        wait_drain("drain_redirect");

        // Wrap from 0xFC to 0x00
        redirect_valid = 1'b1;
        redirect_pc = 8'hFC;
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redirect_norun_idle", mem_rd, 1'b0);
        cyc();
        run = 1'b1;
        expect_word(8'h01, 8'h05, 16'h1234, 8'hFC);
        expect_word(8'h02, 8'h00, 16'h0010, 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("wrap_rd", mem_rd, 1'b1);
            chk("wrap_addr", mem_addr, exp_a[k]);
            cyc();
        end
        run = 1'b0;
        wait_drain("drain_wrap");

        // run dropped after byte 1: word completes, no new start
        expect_word(8'h44, 8'h45, 16'h4746, 8'h04);
        expect_word(8'h48, 8'h49, 16'h4B4A, 8'h08);
        run = 1'b1;
        @(negedge clk);
        chk("rundrop_addr0", mem_addr, 8'h04);
        cyc();
        @(negedge clk);
        chk("rundrop_addr1", mem_addr, 8'h05);
        cyc();
        run = 1'b0;
        @(negedge clk);
        chk("rundrop_byte2_rd", mem_rd, 1'b1);
        chk("rundrop_byte2_addr", mem_addr, 8'h06);
        cyc();
        @(negedge clk);
        chk("rundrop_byte3_rd", mem_rd, 1'b1);
        chk("rundrop_byte3_addr", mem_addr, 8'h07);
        rd_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_rd) rd_seen++;
        end
        chk("no_start_without_run", rd_seen, 0);
        cyc();
        run = 1'b1;
        @(negedge clk);
        chk("restart_rd", mem_rd, 1'b1);
        chk("restart_addr", mem_addr, 8'h08);
        cyc();
        run = 1'b0;
        wait_drain("drain_rundrop");

        // Reset asserted mid-word
        run = 1'b1;
        @(negedge clk);
        chk("midreset_addr0", mem_addr, 8'h0C);
        cyc();
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_rd", mem_rd, 1'b0);
        chk("midreset_addr", mem_addr, 8'h00);
        chk("midreset_valid", inst_valid, 1'b0);
        chk("midreset_q_count", q_count, 3'd0);
        chk("midreset_opcode", inst_opcode, 8'h00);
        chk("midreset_reg", inst_reg, 8'h00);
        chk("midreset_operand", inst_operand, 16'h0000);
        chk("midreset_pc", inst_pc, 8'h00);
        cyc();
        reset = 1'b0;
        expect_word(8'h02, 8'h00, 16'h0010, 8'h00);
        @(negedge clk);
        chk("postreset_rd", mem_rd, 1'b1);
        chk("postreset_addr", mem_addr, 8'h00);
        cyc();
        run = 1'b0;
        wait_drain("drain_reset");
        repeat (10) @(negedge clk);
        chk("final_sb_empty", sbq.size(), 0);
        chk("final_valid", inst_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
